// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns. One pixel per cycle
// with cen_i=1; every output is registered and describes the previous enabled position.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic        sof_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_reg, h_cnt_next;
  logic [11:0] v_cnt_reg, v_cnt_next;
  logic [1:0]  pattern_reg, pattern_next;
  logic [7:0]  frame_reg, frame_next;
  logic [1:0]  vh_blank_reg, vh_blank_next;
  logic [2:0]  dvh_sync_reg, dvh_sync_next;
  logic [23:0] rgb_reg, rgb_next;
  logic        sof_reg, sof_next;
  logic [7:0]  frame_out_reg, frame_out_next;

  logic        at_origin, h_last, v_last;
  logic        h_blank, v_blank, de, hs_on, vs_on;
  logic [23:0] pix_rgb, bar_rgb;
  logic [7:1]  bar_ge;
  logic [2:0]  bar_idx;

  // Bar index is the count of bar edges already passed (thermometer code).
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign bar_ge[gi] = (h_cnt_reg >= 12'(BAR_W * gi));
    end
  endgenerate

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[i]};
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    at_origin = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
    h_last    = (h_cnt_reg == H_LAST);
    v_last    = (v_cnt_reg == V_LAST);

    // The pattern chosen at (0,0) already applies to that first pixel.
    pattern_next = at_origin ? pattern_sel_i : pattern_reg;
    h_cnt_next   = h_last ? 12'd0 : h_cnt_reg + 12'd1;
    v_cnt_next   = v_cnt_reg;
    frame_next   = frame_reg;
    if (h_last) begin
      v_cnt_next = v_last ? 12'd0 : v_cnt_reg + 12'd1;
      if (v_last) begin
        frame_next = frame_reg + 8'd1;
      end
    end

    h_blank = (h_cnt_reg >= H_ACT);
    v_blank = (v_cnt_reg >= V_ACT);
    de      = !h_blank && !v_blank;
    hs_on   = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    vs_on   = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);

    pix_rgb = 24'h000000;
    case (pattern_next)
      2'd0:    pix_rgb = bar_rgb;
      2'd1:    pix_rgb = {3{h_cnt_reg[10:3]}};
      2'd2:    pix_rgb = (h_cnt_reg[6] ^ v_cnt_reg[6] ^ frame_reg[0]) ? 24'hFFFFFF : 24'h000000;
      default: pix_rgb = solid_rgb_i;
    endcase

    vh_blank_next  = {v_blank, h_blank};
    dvh_sync_next  = {de, vs_on ? SYNC_POL : ~SYNC_POL, hs_on ? SYNC_POL : ~SYNC_POL};
    rgb_next       = de ? pix_rgb : 24'h000000;
    sof_next       = at_origin;
    frame_out_next = frame_reg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      pattern_reg   <= '0;
      frame_reg     <= '0;
      vh_blank_reg  <= 2'b11;
      dvh_sync_reg  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
      rgb_reg       <= '0;
      sof_reg       <= 1'b0;
      frame_out_reg <= '0;
    end else if (cen_i) begin
      h_cnt_reg     <= h_cnt_next;
      v_cnt_reg     <= v_cnt_next;
      pattern_reg   <= pattern_next;
      frame_reg     <= frame_next;
      vh_blank_reg  <= vh_blank_next;
      dvh_sync_reg  <= dvh_sync_next;
      rgb_reg       <= rgb_next;
      sof_reg       <= sof_next;
      frame_out_reg <= frame_out_next;
    end
  end

  assign vh_blank_o  = vh_blank_reg;
  assign dvh_sync_o  = dvh_sync_reg;
  assign vid_rgb_o   = rgb_reg;
  assign sof_o       = sof_reg;
  assign frame_cnt_o = frame_out_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three generator instances (full-size line timing, small frame
// with inverted sync, tiny frame for counter wrap) share one stimulus stream.
module tb_video_timing_gen;

  typedef struct packed {
    logic [1:0]  vhb;
    logic [2:0]  dvh;
    logic [23:0] rgb;
    logic        sof;
    logic [7:0]  fc;
  } obs_t;

  typedef struct packed {
    obs_t        o;
    logic        rst;
    logic        adv;
    logic [1:0]  pat;
    logic [23:0] sol;
    int          h;
    int          v;
  } exp_t;

  localparam int HA[3] = '{1920, 128, 8};
  localparam int HF[3] = '{88, 4, 1};
  localparam int HS[3] = '{44, 6, 1};
  localparam int VA[3] = '{1080, 6, 2};
  localparam int VF[3] = '{4, 2, 1};
  localparam int VS[3] = '{5, 3, 1};
  localparam int HT[3] = '{2200, 144, 11};
  localparam int VT[3] = '{1125, 12, 5};
  localparam bit POL[3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [23:0] solid = 24'h123456;

  logic [1:0]  vhb0, vhb1, vhb2;
  logic [2:0]  dvh0, dvh1, dvh2;
  logic [23:0] rgb0, rgb1, rgb2;
  logic        sof0, sof1, sof2;
  logic [7:0]  fc0, fc1, fc2;

  int tests_run = 0;
  int fail_cnt  = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // reference model state (written by stimulus only)
  int   mh[3], mv[3], mpat[3], mfr[3];
  exp_t last_exp[3];

  // monitor bookkeeping (written by monitor only)
  int since_cnt[3], prev_fr[3];
  bit since_ok[3], fr_ok[3];

  always #5 clk = ~clk;

  video_timing_gen u_full (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .pattern_sel_i(sel), .solid_rgb_i(solid),
    .vh_blank_o(vhb0), .dvh_sync_o(dvh0), .vid_rgb_o(rgb0), .sof_o(sof0), .frame_cnt_o(fc0)
  );

  video_timing_gen #(
    .H_ACTIVE(128), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .pattern_sel_i(sel), .solid_rgb_i(solid),
    .vh_blank_o(vhb1), .dvh_sync_o(dvh1), .vid_rgb_o(rgb1), .sof_o(sof1), .frame_cnt_o(fc1)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_tiny (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .pattern_sel_i(sel), .solid_rgb_i(solid),
    .vh_blank_o(vhb2), .dvh_sync_o(dvh2), .vid_rgb_o(rgb2), .sof_o(sof2), .frame_cnt_o(fc2)
  );

  function automatic logic [23:0] bar_colour(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pattern_pix(input int p, input int h, input int v,
                                              input int f, input int ha, input logic [23:0] s);
    int b;
    logic [7:0] g;
    case (p)
      0: begin
        b = h / (ha / 8);
        if (b > 7) b = 7;
        return bar_colour(b);
      end
      1: begin
        g = 8'((h >> 3) & 255);
        return {g, g, g};
      end
      2: return ((((h >> 6) ^ (v >> 6) ^ f) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return s;
    endcase
  endfunction

  task automatic model_step(input int k);
    exp_t e;
    bit   hb, vb, de;
    if (rst) begin
      mh[k] = 0; mv[k] = 0; mpat[k] = 0; mfr[k] = 0;
      e = '0;
      e.o.vhb = 2'b11;
      e.o.dvh = {1'b0, ~POL[k], ~POL[k]};
      e.rst = 1'b1;
    end else if (cen) begin
      e = '0;
      if (mh[k] == 0 && mv[k] == 0) mpat[k] = int'(sel);
      hb = (mh[k] >= HA[k]);
      vb = (mv[k] >= VA[k]);
      de = !hb && !vb;
      e.o.vhb = {vb, hb};
      e.o.dvh[2] = de;
      e.o.dvh[1] = (mv[k] >= VA[k] + VF[k] && mv[k] < VA[k] + VF[k] + VS[k]) ? POL[k] : ~POL[k];
      e.o.dvh[0] = (mh[k] >= HA[k] + HF[k] && mh[k] < HA[k] + HF[k] + HS[k]) ? POL[k] : ~POL[k];
      e.o.rgb = de ? pattern_pix(mpat[k], mh[k], mv[k], mfr[k], HA[k], solid) : 24'h0;
      e.o.sof = (mh[k] == 0 && mv[k] == 0);
      e.o.fc  = 8'(mfr[k]);
      e.adv = 1'b1;
      e.pat = 2'(mpat[k]);
      e.sol = solid;
      e.h = mh[k];
      e.v = mv[k];
      mh[k]++;
      if (mh[k] == HT[k]) begin
        mh[k] = 0;
        mv[k]++;
        if (mv[k] == VT[k]) begin
          mv[k] = 0;
          mfr[k] = (mfr[k] + 1) % 256;
        end
      end
    end else begin
      e = last_exp[k];
      e.rst = 1'b0;
      e.adv = 1'b0;
    end
    last_exp[k] = e;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input logic r, input logic c);
    rst = r;
    cen = c;
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) drive(1'b0, (i % period) == 0);
  endtask

  task automatic lit(input int k, input string nm, input int h, input int v,
                     input logic [23:0] got, input logic [23:0] want);
    tests_run++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s inst%0d h=%0d v=%0d got=%h want=%h", nm, k, h, v, got, want);
    end
  endtask

  task automatic check_entry(input int k, input obs_t act, input exp_t e);
    tests_run++;
    if (act !== e.o) begin
      fail_cnt++;
      $display("FAIL pix inst%0d h=%0d v=%0d got vhb=%b dvh=%b rgb=%h sof=%b fc=%0d want vhb=%b dvh=%b rgb=%h sof=%b fc=%0d",
               k, e.h, e.v, act.vhb, act.dvh, act.rgb, act.sof, act.fc,
               e.o.vhb, e.o.dvh, e.o.rgb, e.o.sof, e.o.fc);
    end
    if (e.rst) begin
      lit(k, "rst_vh_blank", 0, 0, 24'(act.vhb), 24'h3);
      lit(k, "rst_dvh_sync", 0, 0, 24'(act.dvh), (k == 1) ? 24'h3 : 24'h0);
      lit(k, "rst_rgb", 0, 0, act.rgb, 24'h0);
      lit(k, "rst_sof", 0, 0, 24'(act.sof), 24'h0);
      lit(k, "rst_frame", 0, 0, 24'(act.fc), 24'h0);
      since_ok[k] = 1'b0;
      fr_ok[k] = 1'b0;
    end else if (e.adv) begin
      if (e.o.sof) begin
        if (since_ok[k]) lit(k, "sof_period", e.h, e.v, 24'(since_cnt[k]), 24'(HT[k] * VT[k]));
        since_ok[k] = 1'b1;
        since_cnt[k] = 1;
        if (fr_ok[k]) begin
          if (prev_fr[k] == 255) lit(k, "frame_wrap", e.h, e.v, 24'(act.fc), 24'h0);
          else lit(k, "frame_inc", e.h, e.v, 24'(act.fc), 24'(prev_fr[k] + 1));
        end
        fr_ok[k] = 1'b1;
        prev_fr[k] = int'(e.o.fc);
      end else begin
        since_cnt[k]++;
      end
      if (k == 0) begin
        if (e.h == 0 && e.v == 0) begin
          lit(k, "first_sof", e.h, e.v, 24'(act.sof), 24'h1);
          lit(k, "first_de", e.h, e.v, 24'(act.dvh[2]), 24'h1);
          if (e.pat == 2'd0) lit(k, "first_white", e.h, e.v, act.rgb, 24'hFFFFFF);
        end
        if (e.pat == 2'd0) begin
          case (e.h)
            239:  lit(k, "bar_white", e.h, e.v, act.rgb, 24'hFFFFFF);
            240:  lit(k, "bar_yellow", e.h, e.v, act.rgb, 24'hFFFF00);
            1919: lit(k, "bar_black", e.h, e.v, act.rgb, 24'h000000);
            default: ;
          endcase
        end
        if (e.pat == 2'd1 && e.h == 1919) lit(k, "ramp_end", e.h, e.v, act.rgb, 24'hEFEFEF);
        case (e.h)
          1919: lit(k, "hblank_lo", e.h, e.v, 24'(act.vhb[0]), 24'h0);
          1920: begin
            lit(k, "hblank_hi", e.h, e.v, 24'(act.vhb[0]), 24'h1);
            lit(k, "de_lo", e.h, e.v, 24'(act.dvh[2]), 24'h0);
          end
          2199: lit(k, "hblank_end", e.h, e.v, 24'(act.vhb[0]), 24'h1);
          2007: lit(k, "hsync_pre", e.h, e.v, 24'(act.dvh[0]), 24'h0);
          2008: lit(k, "hsync_first", e.h, e.v, 24'(act.dvh[0]), 24'h1);
          2051: lit(k, "hsync_last", e.h, e.v, 24'(act.dvh[0]), 24'h1);
          2052: lit(k, "hsync_post", e.h, e.v, 24'(act.dvh[0]), 24'h0);
          default: ;
        endcase
      end
      if (k == 1) begin
        case (e.h)
          131: lit(k, "hsync_pre", e.h, e.v, 24'(act.dvh[0]), 24'h1);
          132: lit(k, "hsync_first", e.h, e.v, 24'(act.dvh[0]), 24'h0);
          137: lit(k, "hsync_last", e.h, e.v, 24'(act.dvh[0]), 24'h0);
          138: lit(k, "hsync_post", e.h, e.v, 24'(act.dvh[0]), 24'h1);
          default: ;
        endcase
        if (e.h == 0) begin
          case (e.v)
            5:  lit(k, "vblank_lo", e.h, e.v, 24'(act.vhb[1]), 24'h0);
            6:  lit(k, "vblank_hi", e.h, e.v, 24'(act.vhb[1]), 24'h1);
            7:  lit(k, "vsync_pre", e.h, e.v, 24'(act.dvh[1]), 24'h1);
            8:  lit(k, "vsync_first", e.h, e.v, 24'(act.dvh[1]), 24'h0);
            10: lit(k, "vsync_last", e.h, e.v, 24'(act.dvh[1]), 24'h0);
            11: lit(k, "vsync_post", e.h, e.v, 24'(act.dvh[1]), 24'h1);
            default: ;
          endcase
        end
        if (e.pat == 2'd2 && e.v == 0) begin
          if (e.h == 63) lit(k, "checker_l", e.h, e.v, act.rgb, e.o.fc[0] ? 24'hFFFFFF : 24'h0);
          if (e.h == 64) lit(k, "checker_r", e.h, e.v, act.rgb, e.o.fc[0] ? 24'h0 : 24'hFFFFFF);
        end
        if (e.pat == 2'd3 && e.h == 0 && e.v == 0) lit(k, "solid_sof", e.h, e.v, act.rgb, e.sol);
      end
    end
  endtask

  // Monitor: one expectation per clock per instance, checked on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        obs_t act;
        exp_t e;
        bit   have;
        have = 1'b0;
        case (k)
          0: begin
            act = {vhb0, dvh0, rgb0, sof0, fc0};
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          end
          1: begin
            act = {vhb1, dvh1, rgb1, sof1, fc1};
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          end
          default: begin
            act = {vhb2, dvh2, rgb2, sof2, fc2};
            if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          end
        endcase
        if (have) check_entry(k, act, e);
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    run(4460, 1);
    // mid-frame switch to solid with 1-in-3 enable; solid colour changes live
    sel = 2'd3;
    run(5184, 3);
    solid = 24'hA5C3E1;
    run(5184, 3);
    sel = 2'd2;
    run(3500, 1);
    // mid-frame reset with ramp selected: ramp starts at the restart pixel
    sel = 2'd1;
    drive(1'b1, 1'b1);
    run(2250, 1);
    sel = 2'd0;
    run(14200, 1);
    #1;
    lit(0, "q_drained", 0, 0, 24'(q0.size() + q1.size() + q2.size()), 24'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 1920, active pixels per line.
REQ-002 SHALL have parameter H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, 1080, active lines per frame.
REQ-004 SHALL have parameter V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter SYNC_POL, 1'b1, asserted level of Hsync and Vsync (1 = active-high).
REQ-006 SHALL have port clk_i, input, 1, clock; the block uses one clock.
REQ-007 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port cen_i, input, 1, pixel clock enable; all state advances only on cycles with cen_i=1.
REQ-009 SHALL have port pattern_sel_i, input, 2, test pattern select.
REQ-010 SHALL have port solid_rgb_i, input, 24, colour for solid pattern, R[23:16] G[15:8] B[7:0].
REQ-011 SHALL have port vh_blank_o, output, 2, {Vblank, Hblank}.
REQ-012 SHALL have port dvh_sync_o, output, 3, {D_sync, Vsync, Hsync}; D_sync = active-video enable.
REQ-013 SHALL have port vid_rgb_o, output, 24, pixel data, R[23:16] G[15:8] B[7:0].
REQ-014 SHALL have port sof_o, output, 1, start-of-frame pulse.
REQ-015 SHALL have port frame_cnt_o, output, 8, frame counter.

Function
REQ-016 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 2200) and v_cnt 0..V_TOTAL-1 (V_TOTAL = 1125); h_cnt increments per cen_i, wraps to 0 and increments v_cnt; v_cnt wraps to 0 after V_TOTAL-1.
REQ-017 SHALL hold all counters and outputs unchanged on cycles with cen_i=0.
REQ-018 SHALL register all outputs; outputs reflect the counter position of the previous enabled cycle (1-cen latency), all outputs mutually aligned.
REQ-019 SHALL drive Hblank=1 iff h_cnt >= H_ACTIVE; Vblank=1 iff v_cnt >= V_ACTIVE; D_sync=1 iff both blanks are 0.
REQ-020 SHALL drive Hsync=SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
REQ-021 SHALL drive Vsync=SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines, changing at h_cnt=0), else ~SYNC_POL.
REQ-022 SHALL output vid_rgb_o = 24'h0 whenever D_sync=0.
REQ-023 SHALL in active video generate per active pattern: 0 = 8 colour bars of H_ACTIVE/8 px (white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000); 1 = grey ramp R=G=B=h_cnt[10:3]; 2 = 64x64 checkerboard, white where h_cnt[6]^v_cnt[6]^frame_cnt[0]=1 else black; 3 = solid_rgb_i.
REQ-024 SHALL latch pattern_sel_i into the active pattern only on the enabled cycle where h_cnt=0 and v_cnt=0; mid-frame changes take effect next frame; solid_rgb_i is sampled live.
REQ-025 SHALL pulse sof_o high for exactly one enabled output pixel, the one for (h=0, v=0), and low otherwise; with cen_i=0 following, sof_o holds per REQ-017.
REQ-026 SHALL increment frame_cnt_o by 1 when v_cnt wraps V_TOTAL-1 -> 0, wrapping 255 -> 0.
REQ-027 SHALL use unsigned widths of 12 bits for h_cnt and v_cnt; parameter sums exceeding 4095 are unsupported.

Reset
REQ-028 SHALL on rst_i=1 (any cycle, regardless of cen_i) set h_cnt=0, v_cnt=0, active pattern=0, frame_cnt_o=0, vh_blank_o=2'b11, dvh_sync_o={1'b0,~SYNC_POL,~SYNC_POL}, vid_rgb_o=0, sof_o=0.
REQ-029 SHALL after reset release emit pixel (0,0) with sof_o=1 on the first cen_i=1 cycle.
REQ-030 SHALL on reset mid-frame abandon the frame immediately; no partial-frame count is recorded.

Verification
REQ-031 SHALL cover reset then continuous cen_i=1 -> first output pixel has sof_o=1, D_sync=1, vid_rgb_o=FFFFFF (pattern 0); sof_o period 2,475,000 cen cycles.
REQ-032 SHALL cover line timing with defaults -> Hblank high for output h=1920..2199, Hsync high for h=2008..2051 (44 px), D_sync low at h=1920.
REQ-033 SHALL cover frame timing -> Vblank high for lines 1080..1124, Vsync high lines 1084..1088, frame_cnt_o 255 -> 0 after 256 frames.
REQ-034 SHALL cover colour bars -> pixel h=239 FFFFFF, h=240 FFFF00, h=1919 000000; pattern 1 at h=1919 gives EFEFEF.
REQ-035 SHALL cover cen_i toggling 1-in-3 and pattern_sel_i changed 0->3 at v=500 -> outputs frozen on cen_i=0, solid_rgb_i appears only from next frame (0,0).
REQ-036 SHALL cover rst_i asserted at v=600, h=100 -> outputs take REQ-028 values next cycle, frame_cnt_o=0, restart at (0,0).
